reset_release_sequencer: RTL and testbench

//  Sequences reset release for N downstream reset domains from one async reset.
//  - Deassertion passes through an internal SYNC_DEPTH-flop async-reset

---
 rtl/reset_release_sequencer.sv | 155 +++++++++++++++
 tb/tb_reset_release_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reset_release_sequencer.sv
// Staggered reset-release sequencer: synchronizes async reset deassertion, then frees domains 0..N-1 in order.
// Optional SW warm reset enabled by defining RESET_SEQ_SW_RESET_EN.
module reset_release_sequencer #(
   parameter int unsigned N_DOMAINS      = 4,
   parameter int unsigned SYNC_DEPTH     = 3,
   parameter int unsigned STAGGER_CYCLES = 16,
   parameter int unsigned SW_HOLD_CYCLES = 8,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_sw_req,
   output logic                 io_sw_ack,
   output logic [N_DOMAINS-1:0] io_rst_out,
   output logic                 io_done,
   output logic [1:0]           io_state
);

   localparam logic [1:0] ST_SYNC      = 2'd0;
   localparam logic [1:0] ST_RELEASE   = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;
   localparam logic [1:0] ST_SW_ASSERT = 2'd3;

   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(SW_HOLD_CYCLES);

   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  sync_done;
   logic                  sw_req_ok;

   logic [1:0]            state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [N_DOMAINS-1:0]  rst_nxt, shifted;
   logic                  done_nxt, ack_nxt;
   logic                  armed, armed_nxt;
   logic                  sw_pending, pend_nxt;
   logic                  go_q, go_nxt;
   logic                  last_step;

`ifdef RESET_SEQ_SW_RESET_EN
   assign sw_req_ok = io_sw_req;
`else
   logic unused_sw_req;
   assign unused_sw_req = io_sw_req;
   assign sw_req_ok     = 1'b0;
`endif

   // Deassertion synchronizer: cleared asynchronously, fills with ones after release
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
   end

   assign sync_done = sync_q[SYNC_DEPTH-1];

   // Releasing one domain is a left shift; the sequence ends when the vector empties
   assign shifted   = N_DOMAINS'(io_rst_out << 1);
   assign last_step = (shifted == '0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rst_nxt   = io_rst_out;
      done_nxt  = io_done;
      ack_nxt   = 1'b0;
      armed_nxt = armed;
      pend_nxt  = sw_pending;
      go_nxt    = 1'b0;

      case (state)
         ST_SYNC: begin
            if (sync_done) begin
               rst_nxt = shifted;
               cnt_nxt = '0;
               if (last_step) begin
                  state_nxt = ST_RUN;
                  done_nxt  = 1'b1;
               end else begin
                  state_nxt = ST_RELEASE;
               end
            end
         end
         ST_RELEASE: begin
            if (cnt == STAGGER_LAST) begin
               rst_nxt = shifted;
               cnt_nxt = '0;
               if (last_step) begin
                  state_nxt = ST_RUN;
                  done_nxt  = 1'b1;
                  ack_nxt   = sw_pending;
                  pend_nxt  = 1'b0;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            // Request is sampled on one edge and acted on at the next
            go_nxt = armed & sw_req_ok;
            if (go_q) begin
               rst_nxt   = '1;
               done_nxt  = 1'b0;
               cnt_nxt   = '0;
               state_nxt = ST_SW_ASSERT;
            end
         end
         ST_SW_ASSERT: begin
            if (cnt == HOLD_LAST) begin
               rst_nxt = shifted;
               cnt_nxt = '0;
               if (last_step) begin
                  state_nxt = ST_RUN;
                  done_nxt  = 1'b1;
                  ack_nxt   = 1'b1;
               end else begin
                  state_nxt = ST_RELEASE;
                  pend_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = ST_SYNC;
      endcase

      // Ack disarms; only a low request re-arms
      if (ack_nxt)         armed_nxt = 1'b0;
      else if (!sw_req_ok) armed_nxt = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_SYNC;
         cnt        <= '0;
         io_rst_out <= '1;
         io_done    <= 1'b0;
         io_sw_ack  <= 1'b0;
         armed      <= 1'b1;
         sw_pending <= 1'b0;
         go_q       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         io_rst_out <= rst_nxt;
         io_done    <= done_nxt;
         io_sw_ack  <= ack_nxt;
         armed      <= armed_nxt;
         sw_pending <= pend_nxt;
         go_q       <= go_nxt;
      end
   end

   assign io_state = state;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer against a timeline-arithmetic reference model.
module tb_reset_release_sequencer;

   localparam int N = 4;
   localparam int D = 3;
   localparam int S = 16;
   localparam int H = 8;
   localparam int MASK = (1 << N) - 1;
`ifdef RESET_SEQ_SW_RESET_EN
   localparam bit SW_EN = 1'b1;
`else
   localparam bit SW_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         io_sw_req = 1'b0;
   logic         io_sw_ack;
   logic [N-1:0] io_rst_out;
   logic         io_done;
   logic [1:0]   io_state;

   int checks = 0;
   int errors = 0;

   // Reference model: edge count since release and the edge at which domain 0 frees
   int n, rel0, exp_rst, exp_state;
   bit pending, armed, exp_done, exp_ack;

   reset_release_sequencer #(
      .N_DOMAINS(N), .SYNC_DEPTH(D), .STAGGER_CYCLES(S), .SW_HOLD_CYCLES(H), .CNT_W(8)
   ) dut (
      .clock(clock), .reset(reset), .io_sw_req(io_sw_req), .io_sw_ack(io_sw_ack),
      .io_rst_out(io_rst_out), .io_done(io_done), .io_state(io_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic check_all();
      check("rst_out", 32'(io_rst_out), 32'(exp_rst));
      check("done",    32'(io_done),    32'(exp_done));
      check("sw_ack",  32'(io_sw_ack),  32'(exp_ack));
      check("state",   32'(io_state),   32'(exp_state));
   endtask

   function automatic int released(input int e, input int r0);
      int r;
      if (e < r0) return 0;
      r = 1 + (e - r0) / S;
      return (r > N) ? N : r;
   endfunction

   task automatic model_reset();
      n = 0; rel0 = D + 1; pending = 0; armed = 1;
      exp_rst = MASK; exp_done = 0; exp_ack = 0; exp_state = 0;
   endtask

   task automatic model_edge(input bit req);
      bit prev_done;
      int r;
      prev_done = exp_done;
      n++;
      r = released(n, rel0);
      exp_rst  = MASK & ~((1 << r) - 1);
      exp_done = (r == N);
      exp_ack  = pending && (n == rel0 + (N - 1) * S);
      exp_state = (r == N) ? 2 : (r > 0) ? 1 : (pending ? 3 : 0);
      if (exp_ack) pending = 0;
      if (SW_EN && prev_done && armed && req && !pending) begin
         pending = 1;
         rel0 = n + H + 2;
      end
      if (exp_ack)  armed = 0;
      else if (!req) armed = 1;
   endtask

   // One clock: advance the model on the edge, compare just after it
   task automatic step();
      @(posedge clock);
      if (reset) model_reset();
      else       model_edge(io_sw_req);
      #1;
      check_all();
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic assert_reset_now();
      reset = 1'b1;
      #1;
      model_reset();
      check_all();
   endtask

   initial begin
      model_reset();
      #1;
      assert_reset_now();
      steps(2);
      reset = 1'b0;

      // Cold release timeline: 1110@4, 1100@20, 1000@36, 0000@52
      steps(70);

      // Reset reasserted mid-RELEASE, then a fresh timeline
      reset = 1'b1; #1; model_reset(); check_all();
      reset = 1'b0;
      steps(25);
      assert_reset_now();
      steps(2);
      reset = 1'b0;
      steps(60);

      // SW request held high across the ack: exactly one warm sequence
      io_sw_req = 1'b1;
      steps(150);
      // Drop for one cycle to re-arm, then request again
      io_sw_req = 1'b0;
      step();
      io_sw_req = 1'b1;
      steps(80);
      io_sw_req = 1'b0;
      steps(3);

      // Request toggling during SYNC/RELEASE is ignored
      assert_reset_now();
      step();
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         io_sw_req = 1'($urandom_range(0, 1));
         step();
      end
      io_sw_req = 1'b0;
      steps(20);

      // Random request levels with occasional sub-cycle reset glitches
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) io_sw_req = ~io_sw_req;
         step();
         if ($urandom_range(0, 399) == 0) begin
            #2;
            assert_reset_now();
            #1 reset = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
